div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 clk  in  1  -- single clock; all state updates on rising edge.
REQ-002 rst  in  1  -- asynchronous, active-high reset.
REQ-003 start  in  1  -- request; operands/op sampled on the edge where start=1 is accepted.
REQ-004 op  in  2  -- 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-005 word  in  1  -- 1 = RV64 W-variant (32-bit operation).
REQ-006 a  in  64  -- dividend.
REQ-007 b  in  64  -- divisor.
REQ-008 kill  in  1  -- pipeline flush; aborts the operation in flight.
REQ-009 busy  out  1  -- high in CALC and FIX.
REQ-010 done  out  1  -- one-cycle pulse; result valid while high.
REQ-011 result  out  64  -- registered quotient/remainder; feeds one writeback-select input.

Function
REQ-012 States SHALL be IDLE, CALC, FIX, DONE; busy=(CALC|FIX), done=(DONE).
REQ-013 start SHALL be accepted only in IDLE or DONE; ignored in CALC/FIX.
REQ-014 On accept: latch |a|, |b| (signed ops) or raw values (unsigned ops), record quotient/remainder signs, load iteration count K=64 (word=0) or K=32 (word=1), go to CALC.
REQ-015 word=1: operands SHALL be a[31:0]/b[31:0], sign-extended for DIV/REM, zero-extended for DIVU/REMU.
REQ-016 CALC SHALL perform one restoring shift-subtract step per cycle for exactly K cycles, then go to FIX.
REQ-017 FIX SHALL apply sign correction (quotient negative iff operand signs differ; remainder takes dividend sign), select quotient or remainder per op, write result, go to DONE.
REQ-018 word=1 result SHALL be the 32-bit value sign-extended to 64 bits, for all four ops.
REQ-019 Normal latency: accept at edge N -> done high in the cycle after edge N+K+1 (K+2 cycles).
REQ-020 Divide by zero SHALL bypass CALC: accept -> DONE next edge; quotient = all ones, remainder = dividend (after word extension).
REQ-021 Signed overflow (dividend most negative, divisor -1, at operating width) SHALL bypass CALC: quotient = dividend, remainder = 0.
REQ-022 DONE SHALL last one cycle, then IDLE unless start accepted in that cycle.
REQ-023 result SHALL hold its value until the next FIX or special-case write.
REQ-024 kill=1 SHALL force IDLE on the next edge from any state, no done pulse, result unchanged; kill has priority over simultaneous start.

Reset
REQ-025 rst SHALL asynchronously force state=IDLE, busy=0, done=0, result=0, iteration counter=0.
REQ-026 Reset mid-operation SHALL discard the operation; no done after release.
REQ-027 First start SHALL be accepted on the first rising edge with rst=0.

Structure
REQ-028 op encodings and state encodings SHALL live in the shared CPU constants package, alongside the writeback-select encodings.
REQ-029 Iteration counter SHALL be 7 bits; remainder accumulator 65 bits.
REQ-030 No sub-module required; datapath and FSM inline in div_unit.

Verification
REQ-031 DIVU, word=0, a=100, b=7 -> done after 66 cycles, result=14; REMU same operands -> result=2.
REQ-032 DIV, word=0, a=-7, b=2 -> result=-3 (0xFFFF_FFFF_FFFF_FFFD); REM -> result=-1.
REQ-033 DIVU, b=0, a=0x1234 -> done next cycle, result=0xFFFF_FFFF_FFFF_FFFF; REMU -> 0x1234.
REQ-034 DIV, word=1, a=0x8000_0000, b=0xFFFF_FFFF -> result=0xFFFF_FFFF_8000_0000 in 2 cycles; REM -> 0.
REQ-035 DIVU, word=1, a=0xFFFF_FFFF, b=1 -> result=0xFFFF_FFFF_FFFF_FFFF after 34 cycles.
REQ-036 kill asserted 10 cycles into a 64-bit DIV, start held in same cycle -> IDLE, no done, result unchanged; rst mid-CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared CPU constants: divider op/state encodings and writeback-select codes.
package div_unit_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } div_state_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_DIV = 2'b10,
    WB_CSR = 2'b11
  } wb_sel_e;

  localparam logic [6:0] ITER_D = 7'd64;
  localparam logic [6:0] ITER_W = 7'd32;

  function automatic logic op_is_signed(input logic [1:0] o);
    return ~o[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] o);
    return o[1];
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider for RV64 DIV/DIVU/REM/REMU and their W variants.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        word,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);
  import div_unit_pkg::*;

  div_state_e  r_state;
  logic        r_busy;
  logic        r_done;
  logic [63:0] r_result;
  logic [6:0]  r_cnt;
  logic [64:0] r_rem;
  logic [63:0] r_quo;
  logic [63:0] r_div;
  logic        r_is_rem;
  logic        r_word;
  logic        r_q_neg;
  logic        r_r_neg;
  logic        r_special;
  logic [63:0] r_spec_val;

  logic        w_signed;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [63:0] w_a_abs;
  logic [63:0] w_b_abs;
  logic [63:0] w_a_wext;
  logic        w_div_zero;
  logic        w_a_min;
  logic        w_b_m1;
  logic        w_ovf;
  logic [63:0] w_spec_val;

  // Operand conditioning at the operating width.
  assign w_signed = op_is_signed(op);
  assign w_a_ext  = word ? (w_signed ? sext32(a[31:0]) : {32'b0, a[31:0]}) : a;
  assign w_b_ext  = word ? (w_signed ? sext32(b[31:0]) : {32'b0, b[31:0]}) : b;
  assign w_a_neg  = w_signed & w_a_ext[63];
  assign w_b_neg  = w_signed & w_b_ext[63];
  assign w_a_abs  = w_a_neg ? (64'd0 - w_a_ext) : w_a_ext;
  assign w_b_abs  = w_b_neg ? (64'd0 - w_b_ext) : w_b_ext;
  assign w_a_wext = word ? sext32(a[31:0]) : a;

  assign w_div_zero = (w_b_ext == 64'd0);
  assign w_a_min    = word ? (a[31:0] == 32'h8000_0000) : (a == 64'h8000_0000_0000_0000);
  assign w_b_m1     = word ? (b[31:0] == 32'hFFFF_FFFF) : (b == 64'hFFFF_FFFF_FFFF_FFFF);
  assign w_ovf      = w_signed & w_a_min & w_b_m1;

  always_comb begin
    w_spec_val = '0;
    if (w_div_zero)
      w_spec_val = op_is_rem(op) ? w_a_wext : 64'hFFFF_FFFF_FFFF_FFFF;
    else
      w_spec_val = op_is_rem(op) ? 64'd0 : w_a_wext;
  end

  logic [64:0] w_shift;
  logic [65:0] w_sub;
  logic        w_ge;
  logic [64:0] w_rem_nxt;
  logic [63:0] w_quo_nxt;

  // One restoring step; a set accumulator MSB means the shifted value certainly exceeds the divisor.
  assign w_shift   = {r_rem[63:0], r_quo[63]};
  assign w_sub     = {1'b0, w_shift} - {2'b00, r_div};
  assign w_ge      = r_rem[64] | ~w_sub[65];
  assign w_rem_nxt = w_ge ? w_sub[64:0] : w_shift;
  assign w_quo_nxt = {r_quo[62:0], w_ge};

  logic [63:0] w_q_raw;
  logic [63:0] w_q_fix;
  logic [63:0] w_r_fix;
  logic [63:0] w_sel;
  logic [63:0] w_fix_val;

  assign w_q_raw   = r_word ? {32'b0, r_quo[31:0]} : r_quo;
  assign w_q_fix   = r_q_neg ? (64'd0 - w_q_raw) : w_q_raw;
  assign w_r_fix   = r_r_neg ? (64'd0 - r_rem[63:0]) : r_rem[63:0];
  assign w_sel     = r_is_rem ? w_r_fix : w_q_fix;
  assign w_fix_val = r_word ? sext32(w_sel[31:0]) : w_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_div      <= '0;
      r_is_rem   <= 1'b0;
      r_word     <= 1'b0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_special  <= 1'b0;
      r_spec_val <= '0;
    end else if (kill) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_is_rem <= op_is_rem(op);
            r_word   <= word;
            r_q_neg  <= w_a_neg ^ w_b_neg;
            r_r_neg  <= w_a_neg;
            r_rem    <= '0;
            r_quo    <= word ? {w_a_abs[31:0], 32'b0} : w_a_abs;
            r_div    <= w_b_abs;
            r_busy   <= 1'b1;
            // Special cases skip the iterations; FIX only publishes the precomputed value.
            if (w_div_zero || w_ovf) begin
              r_special  <= 1'b1;
              r_spec_val <= w_spec_val;
              r_cnt      <= '0;
              r_state    <= S_FIX;
            end else begin
              r_special <= 1'b0;
              r_cnt     <= word ? ITER_W : ITER_D;
              r_state   <= S_CALC;
            end
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 7'd1;
          if (r_cnt == 7'd1)
            r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= r_special ? r_spec_val : w_fix_val;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic        word;
  logic [63:0] a;
  logic [63:0] b;
  logic        kill;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .word   (word),
    .a      (a),
    .b      (b),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Accept edge counts as cycle 1; cyc is the cycle count at which done was first seen.
  task automatic run_op(input logic [1:0] o, input logic w, input logic [63:0] av,
                        input logic [63:0] bv, output int cyc, output logic [63:0] res);
    @(negedge clk);
    op = o; word = w; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; word = 1'b0; a = '0; b = '0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    op = OP_DIVU; a = 64'd5; b = 64'd0; start = 1'b1; rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_start_busy got %b exp 1", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL first_start_done got %b exp 1", done); end
    checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL first_start_result got %h exp ffffffffffffffff", result); end
  endtask

  task automatic test_unsigned();
    logic [1:0]  t_op  [4] = '{OP_DIVU, OP_REMU, OP_DIVU, OP_DIVU};
    logic        t_w   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [63:0] t_a   [4] = '{64'd100, 64'd100, 64'h0000_0000_FFFF_FFFF, 64'hDEAD_BEEF_0000_0064};
    logic [63:0] t_b   [4] = '{64'd7, 64'd7, 64'd1, 64'h1234_5678_0000_0007};
    logic [63:0] t_exp [4] = '{64'd14, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd14};
    int          t_cyc [4] = '{66, 66, 34, 34};
    int cyc;
    logic [63:0] res;
    for (int i = 0; i < 4; i++) begin
      run_op(t_op[i], t_w[i], t_a[i], t_b[i], cyc, res);
      checks++; if (cyc != t_cyc[i]) begin errors++; $display("FAIL unsigned_latency[%0d] got %0d exp %0d", i, cyc, t_cyc[i]); end
      checks++; if (res !== t_exp[i]) begin errors++; $display("FAIL unsigned_result[%0d] got %h exp %h", i, res, t_exp[i]); end
    end
  endtask

  task automatic test_signed();
    logic [1:0]  t_op  [7] = '{OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIV, OP_DIV, OP_REM};
    logic        t_w   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [63:0] t_a   [7] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd7, 64'd7,
                               64'hFFFF_FFFF_FFFF_FFF9, 64'h0000_0000_FFFF_FFF9, 64'h0000_0000_FFFF_FFF9};
    logic [63:0] t_b   [7] = '{64'd2, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE,
                               64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'd2};
    logic [63:0] t_exp [7] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD,
                               64'd1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF};
    int          t_cyc [7] = '{66, 66, 66, 66, 66, 34, 34};
    int cyc;
    logic [63:0] res;
    for (int i = 0; i < 7; i++) begin
      run_op(t_op[i], t_w[i], t_a[i], t_b[i], cyc, res);
      checks++; if (cyc != t_cyc[i]) begin errors++; $display("FAIL signed_latency[%0d] got %0d exp %0d", i, cyc, t_cyc[i]); end
      checks++; if (res !== t_exp[i]) begin errors++; $display("FAIL signed_result[%0d] got %h exp %h", i, res, t_exp[i]); end
    end
  endtask

  task automatic test_special();
    logic [1:0]  t_op  [8] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_REMU, OP_DIV, OP_REM, OP_DIV};
    logic        t_w   [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [63:0] t_a   [8] = '{64'h1234, 64'h1234, 64'h0000_0000_8000_0005, 64'h0000_0000_8000_0005,
                               64'h0000_0000_8000_0005, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000,
                               64'h8000_0000_0000_0000};
    logic [63:0] t_b   [8] = '{64'd0, 64'd0, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000,
                               64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
                               64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] t_exp [8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF,
                               64'hFFFF_FFFF_8000_0005, 64'hFFFF_FFFF_8000_0005, 64'hFFFF_FFFF_8000_0000,
                               64'd0, 64'h8000_0000_0000_0000};
    int cyc;
    logic [63:0] res;
    for (int i = 0; i < 8; i++) begin
      run_op(t_op[i], t_w[i], t_a[i], t_b[i], cyc, res);
      checks++; if (cyc != 2) begin errors++; $display("FAIL special_latency[%0d] got %0d exp 2", i, cyc); end
      checks++; if (res !== t_exp[i]) begin errors++; $display("FAIL special_result[%0d] got %h exp %h", i, res, t_exp[i]); end
    end
    // Same operands but unsigned: not an overflow, so it must iterate.
    run_op(OP_DIVU, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, cyc, res);
    checks++; if (cyc != 34) begin errors++; $display("FAIL divuw_no_ovf_latency got %0d exp 34", cyc); end
    checks++; if (res !== 64'd0) begin errors++; $display("FAIL divuw_no_ovf_result got %h exp 0", res); end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    @(negedge clk);
    op = OP_REMU; word = 1'b0; a = 64'd100; b = 64'd7; start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    op = OP_DIVU; a = 64'h55; b = 64'd0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL calc_busy got %b exp 1", busy); end
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 6) start = 1'b0;
    end
    start = 1'b0;
    checks++; if (cyc != 66) begin errors++; $display("FAIL ignore_latency got %0d exp 66", cyc); end
    checks++; if (result !== 64'd2) begin errors++; $display("FAIL ignore_result got %h exp 2", result); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [63:0] res;
    run_op(OP_DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, cyc, res);
    run_op(OP_DIVU, 1'b0, 64'd100, 64'd7, cyc, res);
    checks++; if (cyc != 66) begin errors++; $display("FAIL b2b_latency got %0d exp 66", cyc); end
    checks++; if (res !== 64'd14) begin errors++; $display("FAIL b2b_result got %h exp 14", res); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b exp 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
    checks++; if (result !== 64'd14) begin errors++; $display("FAIL result_hold got %h exp 14", result); end
  endtask

  task automatic test_kill();
    int cyc;
    logic [63:0] res;
    bit seen;
    run_op(OP_DIVU, 1'b0, 64'd100, 64'd7, cyc, res);
    @(negedge clk);
    op = OP_DIV; word = 1'b0; a = 64'd1000; b = 64'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1; start = 1'b1; op = OP_DIVU; b = 64'd0;
    @(posedge clk); #1;
    kill = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL kill_done got %b exp 0", done); end
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL kill_no_done got done=1 exp done=0"); end
    checks++; if (result !== 64'd14) begin errors++; $display("FAIL kill_result got %h exp 14", result); end
  endtask

  task automatic test_rst_mid();
    int cyc;
    logic [63:0] res;
    bit seen;
    @(negedge clk);
    op = OP_DIV; word = 1'b0; a = 64'd12345; b = 64'd17; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b exp 0", done); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL rst_mid_result got %h exp 0", result); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL rst_mid_no_done got done=1 exp done=0"); end
    run_op(OP_DIV, 1'b0, 64'd12345, 64'd17, cyc, res);
    checks++; if (res !== 64'd726) begin errors++; $display("FAIL rst_recover_result got %h exp 2d6", res); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_busy_ignore();
    test_back_to_back();
    test_kill();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
